reg_pipe_hs: RTL and testbench

Parametrised chain of DEPTH edge-triggered register stages, each WIDTH bits wide, with a per-stage valid bit and valid/ready flow control.
It generalises the single async-reset D flip-flop into a stallable pipeline register with bubble collapsing, synchronous flush and an occupancy count.
It is used as a drop-in retiming/buffering slice between producer and consumer blocks.

---
 rtl/reg_pipe_hs.sv | 111 +++++++++++
 tb/tb_reg_pipe_hs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe_hs.sv
// Stallable DEPTH-stage register pipeline with per-stage valid, bubble collapsing and flush.
// Latency DEPTH cycles from the accept cycle to out_valid; full throughput when streaming.
// Backpressure: ready ripples back combinationally, so empty stages keep accepting while out_ready=0.
module reg_pipe_hs #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] stage_v;
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             full_acc;
    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // A stage can take a word if any stage at or after it is empty, or the consumer pops.
    always_comb begin
        full_acc = 1'b1;
        rdy      = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            full_acc = full_acc & stage_v[i];
            rdy[i]   = out_ready | ~full_acc;
        end
    end

    assign in_ready  = rdy[0] & ~clr;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = stage_v[DEPTH-1] & out_ready;
    assign out_valid = stage_v[DEPTH-1];
    assign out_data  = stage_d[DEPTH-1];
    assign count     = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             v_q;
        logic             v_d;
        logic [WIDTH-1:0] d_q;
        logic [WIDTH-1:0] d_d;

        if (i == 0) begin : g_head
            assign up_v = in_fire;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = stage_v[i-1];
            assign up_d = stage_d[i-1];
        end

        always_comb begin
            v_d = v_q;
            d_d = d_q;
            if (clr) begin
                v_d = 1'b0;
            end else if (rdy[i]) begin
                v_d = up_v;
                if (up_v) begin
                    d_d = up_d;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= RST_VAL;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign stage_v[i] = v_q;
        assign stage_d[i] = d_q;
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + CW'(1);
        end else if (!in_fire && out_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Directed and randomized checks of reg_pipe_hs against a queue-of-words reference model.
module tb_reg_pipe_hs;

    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ov_first = -1;
    int   acc_cyc;
    int   idx;
    logic last_in_fire;
    int   m_dat [$];
    int   m_pos [$];
    int   got_q [$];

    reg_pipe_hs #(.WIDTH(8), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    // (each word moves one stage forward unless blocked by the word ahead).
    task automatic tick();
        logic exp_ir;
        logic exp_ov;
        logic out_fire;
        int   limit;
        int   np;
        #1;
        exp_ir = !((m_dat.size() == D) && !out_ready) && !clr;
        exp_ov = (m_dat.size() > 0) && (m_pos[0] == D - 1);
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        chk("count", count, m_dat.size());
        if (exp_ov) chk("out_data", out_data, m_dat[0]);
        if (out_valid && ov_first < 0) ov_first = cyc;
        last_in_fire = in_valid && exp_ir;
        out_fire     = exp_ov && out_ready;
        if (out_fire) got_q.push_back(int'(out_data));
        @(posedge clk);
        limit = out_ready ? D : D - 1;
        foreach (m_pos[i]) begin
            np = (m_pos[i] + 1 < limit) ? m_pos[i] + 1 : limit;
            m_pos[i] = np;
            limit = np - 1;
        end
        if (m_pos.size() > 0 && m_pos[0] == D) begin
            void'(m_pos.pop_front());
            void'(m_dat.pop_front());
        end
        if (clr) begin
            m_pos.delete();
            m_dat.delete();
        end else if (last_in_fire) begin
            m_dat.push_back(int'(in_data));
            m_pos.push_back(0);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic expect_range(input string tag, input int first, input int n);
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk(tag, got_q[i], first + i);
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_data", out_data, RV);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Asynchronous reset with words in flight.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'(8'h01 + k);
            tick();
        end
        in_valid = 1'b0;
        chk("fill3_count", count, 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_out_data", out_data, RV);
        m_dat.delete(); m_pos.delete(); got_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("arst_release_in_ready", in_ready, 1);

        // Streaming with latency measurement.
        out_ready = 1'b1;
        ov_first  = -1;
        acc_cyc   = cyc;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'(8'h11 + k);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("stream_latency", ov_first - acc_cyc, D);
        expect_range("stream", 'h11, 8);

        // Backpressure: producer holds each word until accepted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx = 0;
        repeat (6) begin
            in_data = 8'(8'h21 + idx);
            tick();
            if (last_in_fire) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_count", count, 4);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1 chk("bp_in_ready_same_cycle", in_ready, 1);
        for (int g = 0; g < 10 && idx < 6; g++) begin
            in_data = 8'(8'h21 + idx);
            tick();
            if (last_in_fire) idx++;
        end
        in_valid = 1'b0;
        repeat (6) tick();
        expect_range("bp", 'h21, 6);

        // Bubble collapse.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 8'hA2; tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bubble_count", count, 2);
        chk("bubble_out_valid", out_valid, 1);
        chk("bubble_out_data", out_data, 8'hA1);
        out_ready = 1'b1;
        repeat (3) tick();
        expect_range("bubble", 'hA1, 2);

        // Flush a full pipe while a word is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'(8'h30 + k);
            tick();
        end
        in_data = 8'hFF;
        clr = 1'b1;
        tick();
        chk("flush_in_ready", in_ready, 0);
        clr = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        tick();
        expect_range("flush", 0, 0);

        // Simultaneous push and pop on a full pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'(8'h50 + k);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(8'h54 + k);
            tick();
            chk("simul_count", count, 4);
        end
        in_valid = 1'b0;
        repeat (6) tick();
        expect_range("simul", 'h50, 14);

        // Randomized traffic including occasional flushes.
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom % 4) != 0;
            clr       = ($urandom % 25) == 0;
            in_data   = 8'($urandom);
            tick();
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        got_q.delete();
        chk("final_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
